// File: rtl/ddc_out_arbiter.sv
// Four-channel DDC output arbiter: per-channel I/Q pair FIFOs drained round-robin as I then Q words.
// Optional build macro DDC_ARB_DROPCNT_EN adds saturating per-channel drop counters on o_drop_cnt.
module ddc_out_arbiter #(
  parameter int ADBITWIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNTW       = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [3:0]              i_ch_en,
  input  logic [3:0]              i_ddc_flag,
  input  logic [4*ADBITWIDTH-1:0] i_ch_i_data,
  input  logic [4*ADBITWIDTH-1:0] i_ch_q_data,
  input  logic                    i_out_ready,
  input  logic                    i_ovf_clr,
  output logic                    o_out_valid,
  output logic [ADBITWIDTH-1:0]   o_out_data,
  output logic                    o_out_iq,
  output logic [1:0]              o_out_ch,
  output logic [3:0]              o_ovf_flag,
  output logic                    o_busy,
  output logic [4*CNTW-1:0]       o_drop_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND_I = 2'd1,
    ST_SEND_Q = 2'd2
  } state_t;

  logic [ADBITWIDTH-1:0] r_mem_i [4][FIFO_DEPTH];
  logic [ADBITWIDTH-1:0] r_mem_q [4][FIFO_DEPTH];
  logic [AW-1:0]         r_wptr  [4];
  logic [AW-1:0]         r_rptr  [4];
  logic [AW:0]           r_cnt   [4];

  state_t                r_state;
  logic [1:0]            r_rr;
  logic [ADBITWIDTH-1:0] r_hold_q;
  logic                  r_out_valid;
  logic [ADBITWIDTH-1:0] r_out_data;
  logic                  r_out_iq;
  logic [1:0]            r_out_ch;
  logic [3:0]            r_ovf;

  logic [3:0]            w_nonempty;
  logic [3:0]            w_full;
  logic [3:0]            w_req;
  logic [3:0]            w_push;
  logic [3:0]            w_pop;
  logic [3:0]            w_drop;
  logic [1:0]            w_grant;
  logic [1:0]            w_idx;
  logic                  w_found;
  logic                  w_grant_ok;
  logic                  w_do_grant;
  logic [ADBITWIDTH-1:0] w_rd_i;
  logic [ADBITWIDTH-1:0] w_rd_q;

  // FIFO occupancy status
  always_comb begin
    w_nonempty = 4'b0000;
    w_full     = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      w_nonempty[n] = (r_cnt[n] != {(AW+1){1'b0}});
      w_full[n]     = (r_cnt[n] == DEPTH_C);
    end
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    w_grant = 2'd0;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_rr + 2'(k);
      if (!w_found && w_nonempty[w_idx]) begin
        w_grant = w_idx;
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Grant qualification, pop/push/drop decisions and FIFO head read
  always_comb begin
    w_grant_ok = i_enable & (|w_nonempty);
    case (r_state)
      ST_IDLE:   w_do_grant = w_grant_ok;
      ST_SEND_Q: w_do_grant = w_grant_ok & i_out_ready;
      default:   w_do_grant = 1'b0;
    endcase
    if (w_do_grant) begin
      w_pop = 4'b0001 << w_grant;
    end else begin
      w_pop = 4'b0000;
    end
    w_req  = i_ddc_flag & i_ch_en & {4{i_enable}};
    // A full FIFO still accepts a write when its head is popped the same cycle
    w_push = w_req & (~w_full | w_pop);
    w_drop = w_req & w_full & ~w_pop;
    w_rd_i = r_mem_i[w_grant][r_rptr[w_grant]];
    w_rd_q = r_mem_q[w_grant][r_rptr[w_grant]];
  end

  // FIFO sample storage (no reset needed; validity tracked by r_cnt)
  always_ff @(posedge i_clk) begin
    for (int n = 0; n < 4; n++) begin
      if (w_push[n]) begin
        r_mem_i[n][r_wptr[n]] <= i_ch_i_data[n*ADBITWIDTH +: ADBITWIDTH];
        r_mem_q[n][r_wptr[n]] <= i_ch_q_data[n*ADBITWIDTH +: ADBITWIDTH];
      end
    end
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < 4; n++) begin
        r_wptr[n] <= {AW{1'b0}};
        r_rptr[n] <= {AW{1'b0}};
        r_cnt[n]  <= {(AW+1){1'b0}};
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_push[n]) begin
          r_wptr[n] <= r_wptr[n] + AW'(1);
        end
        if (w_pop[n]) begin
          r_rptr[n] <= r_rptr[n] + AW'(1);
        end
        case ({w_push[n], w_pop[n]})
          2'b10:   r_cnt[n] <= r_cnt[n] + (AW+1)'(1);
          2'b01:   r_cnt[n] <= r_cnt[n] - (AW+1)'(1);
          default: r_cnt[n] <= r_cnt[n];
        endcase
      end
    end
  end

  // Arbiter FSM with registered output word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_rr        <= 2'd3;
      r_hold_q    <= {ADBITWIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_out_data  <= {ADBITWIDTH{1'b0}};
      r_out_iq    <= 1'b0;
      r_out_ch    <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_do_grant) begin
            r_hold_q    <= w_rd_q;
            r_rr        <= w_grant;
            r_out_ch    <= w_grant;
            r_out_data  <= w_rd_i;
            r_out_iq    <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= ST_SEND_I;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        ST_SEND_I: begin
          if (i_out_ready) begin
            r_out_data <= r_hold_q;
            r_out_iq   <= 1'b0;
            r_state    <= ST_SEND_Q;
          end
        end
        ST_SEND_Q: begin
          // Back-to-back grant on Q acceptance keeps the port bubble-free
          if (i_out_ready) begin
            if (w_do_grant) begin
              r_hold_q    <= w_rd_q;
              r_rr        <= w_grant;
              r_out_ch    <= w_grant;
              r_out_data  <= w_rd_i;
              r_out_iq    <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= ST_SEND_I;
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow flags; a new drop outranks a clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 4'b0000;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_drop[n]) begin
          r_ovf[n] <= 1'b1;
        end else if (i_ovf_clr) begin
          r_ovf[n] <= 1'b0;
        end
      end
    end
  end

`ifdef DDC_ARB_DROPCNT_EN
  logic [CNTW-1:0] r_drop_cnt [4];

  // Saturating drop counters; a drop coinciding with a clear restarts at one
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < 4; n++) begin
        r_drop_cnt[n] <= {CNTW{1'b0}};
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_drop[n]) begin
          if (i_ovf_clr) begin
            r_drop_cnt[n] <= CNTW'(1);
          end else if (r_drop_cnt[n] != {CNTW{1'b1}}) begin
            r_drop_cnt[n] <= r_drop_cnt[n] + CNTW'(1);
          end
        end else if (i_ovf_clr) begin
          r_drop_cnt[n] <= {CNTW{1'b0}};
        end
      end
    end
  end

  // Pack counters onto the output bus
  always_comb begin
    o_drop_cnt = {(4*CNTW){1'b0}};
    for (int n = 0; n < 4; n++) begin
      o_drop_cnt[n*CNTW +: CNTW] = r_drop_cnt[n];
    end
  end
`else
  assign o_drop_cnt = {(4*CNTW){1'b0}};
`endif

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_iq    = r_out_iq;
  assign o_out_ch    = r_out_ch;
  assign o_ovf_flag  = r_ovf;
  assign o_busy      = (r_state != ST_IDLE) | (|w_nonempty);

endmodule

// File: tb/tb_ddc_out_arbiter.sv
// Directed bench for ddc_out_arbiter: a per-cycle vector table plus hand-written corner sequences.
module tb_ddc_out_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  ch_en = 4'b1111;
  logic [3:0]  ddc_flag = 4'b0000;
  logic [63:0] ch_i_data = 64'h0;
  logic [63:0] ch_q_data = 64'h0;
  logic        out_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_iq;
  logic [1:0]  out_ch;
  logic [3:0]  ovf_flag;
  logic        busy;
  logic [31:0] drop_cnt;

  int n_pass = 0;
  int n_total = 0;

  ddc_out_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_ch_en(ch_en),
    .i_ddc_flag(ddc_flag), .i_ch_i_data(ch_i_data), .i_ch_q_data(ch_q_data),
    .i_out_ready(out_ready), .i_ovf_clr(ovf_clr),
    .o_out_valid(out_valid), .o_out_data(out_data), .o_out_iq(out_iq),
    .o_out_ch(out_ch), .o_ovf_flag(ovf_flag), .o_busy(busy), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  chen;
    logic [3:0]  flag;
    logic [63:0] idata;
    logic [63:0] qdata;
    logic        ready;
    logic        ev;
    logic [15:0] ed;
    logic        eiq;
    logic [1:0]  ech;
    logic        ebusy;
    logic        chkd;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mk(logic r, logic [3:0] ce, logic [3:0] f, logic [63:0] id,
                              logic [63:0] qd, logic rdy, logic v, logic [15:0] d,
                              logic iq, logic [1:0] ch, logic b, logic cd);
    vec_t t;
    t.rst = r; t.chen = ce; t.flag = f; t.idata = id; t.qdata = qd; t.ready = rdy;
    t.ev = v; t.ed = d; t.eiq = iq; t.ech = ch; t.ebusy = b; t.chkd = cd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input string name, input logic [15:0] d, input logic iq, input logic [1:0] ch);
    chk({name, ".valid"}, 32'(out_valid), 32'd1);
    chk({name, ".data"}, 32'(out_data), 32'(d));
    chk({name, ".iq"}, 32'(out_iq), 32'(iq));
    chk({name, ".ch"}, 32'(out_ch), 32'(ch));
  endtask

  task automatic do_reset();
    rst = 1'b1; ddc_flag = 4'b0000; out_ready = 1'b0; ovf_clr = 1'b0; enable = 1'b1; ch_en = 4'b1111;
    tick();
    rst = 1'b0;
  endtask

  logic [63:0] pi, pq;
  logic [7:0]  exp_drop;

  initial begin
    pi = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    pq = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    vecs[0]  = mk(1, 4'hF, 4'h0, 64'h0, 64'h0, 1, 0, 16'h0000, 0, 2'd0, 0, 1);
    vecs[1]  = mk(0, 4'hF, 4'h1, 64'h1234, 64'h5678, 1, 0, 16'h0, 0, 2'd0, 1, 0);
    vecs[2]  = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 1, 16'h1234, 1, 2'd0, 1, 0);
    vecs[3]  = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 1, 16'h5678, 0, 2'd0, 1, 0);
    vecs[4]  = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 0, 16'h0, 0, 2'd0, 0, 0);
    vecs[5]  = mk(1, 4'hF, 4'h0, 64'h0, 64'h0, 1, 0, 16'h0000, 0, 2'd0, 0, 1);
    vecs[6]  = mk(0, 4'hF, 4'hF, pi, pq, 1, 0, 16'h0, 0, 2'd0, 1, 0);
    vecs[7]  = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 1, 16'hA000, 1, 2'd0, 1, 0);
    vecs[8]  = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 1, 16'hB000, 0, 2'd0, 1, 0);
    vecs[9]  = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 1, 16'hA001, 1, 2'd1, 1, 0);
    vecs[10] = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 1, 16'hB001, 0, 2'd1, 1, 0);
    vecs[11] = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 1, 16'hA002, 1, 2'd2, 1, 0);
    vecs[12] = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 1, 16'hB002, 0, 2'd2, 1, 0);
    vecs[13] = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 1, 16'hA003, 1, 2'd3, 1, 0);
    vecs[14] = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 1, 16'hB003, 0, 2'd3, 1, 0);
    vecs[15] = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 0, 16'h0, 0, 2'd0, 0, 0);
    vecs[16] = mk(0, 4'hF, 4'h1, 64'h1111, 64'h2222, 1, 0, 16'h0, 0, 2'd0, 1, 0);
    for (int s = 17; s <= 22; s++) begin
      vecs[s] = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 0, 1, 16'h1111, 1, 2'd0, 1, 0);
    end
    vecs[23] = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 1, 16'h2222, 0, 2'd0, 1, 0);
    vecs[24] = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 0, 16'h0, 0, 2'd0, 0, 0);
    vecs[25] = mk(0, 4'hE, 4'h1, 64'h9999, 64'h9999, 1, 0, 16'h0, 0, 2'd0, 0, 0);
    vecs[26] = mk(0, 4'hF, 4'h0, 64'h0, 64'h0, 1, 0, 16'h0, 0, 2'd0, 0, 0);

    #1;
    for (int v = 0; v < 27; v++) begin
      rst = vecs[v].rst; ch_en = vecs[v].chen; ddc_flag = vecs[v].flag;
      ch_i_data = vecs[v].idata; ch_q_data = vecs[v].qdata; out_ready = vecs[v].ready;
      tick();
      chk($sformatf("vec%0d.valid", v), 32'(out_valid), 32'(vecs[v].ev));
      chk($sformatf("vec%0d.busy", v), 32'(busy), 32'(vecs[v].ebusy));
      chk($sformatf("vec%0d.ovf", v), 32'(ovf_flag), 32'd0);
      if (vecs[v].ev || vecs[v].chkd) begin
        chk($sformatf("vec%0d.data", v), 32'(out_data), 32'(vecs[v].ed));
        chk($sformatf("vec%0d.iq", v), 32'(out_iq), 32'(vecs[v].eiq));
        chk($sformatf("vec%0d.ch", v), 32'(out_ch), 32'(vecs[v].ech));
      end
      if (vecs[v].chkd) begin
        chk($sformatf("vec%0d.drop", v), drop_cnt, 32'd0);
      end
    end
    rst = 1'b0; ch_en = 4'hF; ddc_flag = 4'h0;

    // Overflow on channel 2 while the port is stalled on a channel-0 pair
    do_reset();
    ch_i_data = {48'h0, 16'h0C0C}; ch_q_data = {48'h0, 16'h0D0D}; ddc_flag = 4'b0001;
    tick();
    ddc_flag = 4'b0000;
    tick();
    for (int k = 0; k < 6; k++) begin
      ddc_flag = 4'b0100;
      ch_i_data = {16'h0, 16'h2000 + 16'(k), 32'h0};
      ch_q_data = {16'h0, 16'h3000 + 16'(k), 32'h0};
      tick();
    end
    ddc_flag = 4'b0000;
`ifdef DDC_ARB_DROPCNT_EN
    exp_drop = 8'd2;
`else
    exp_drop = 8'd0;
`endif
    chk("ovf.flag", 32'(ovf_flag), 32'h4);
    chk("ovf.drop2", 32'(drop_cnt[23:16]), 32'(exp_drop));
    chk("ovf.drop_other", 32'({drop_cnt[31:24], drop_cnt[15:0]}), 32'd0);
    chk("ovf.busy", 32'(busy), 32'd1);
    word("ovf.hold", 16'h0C0C, 1'b1, 2'd0);
    out_ready = 1'b1;
    tick();
    word("ovf.q0", 16'h0D0D, 1'b0, 2'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      word($sformatf("ovf.i%0d", k), 16'h2000 + 16'(k), 1'b1, 2'd2);
      tick();
      word($sformatf("ovf.q%0d", k), 16'h3000 + 16'(k), 1'b0, 2'd2);
      tick();
    end
    chk("ovf.drained", 32'(out_valid), 32'd0);
    chk("ovf.idle_busy", 32'(busy), 32'd0);
    chk("ovf.sticky", 32'(ovf_flag), 32'h4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf.cleared", 32'(ovf_flag), 32'd0);
    chk("ovf.cnt_cleared", drop_cnt, 32'd0);

    // Reset while the Q word is on the port
    do_reset();
    ch_i_data = {32'h0, 16'h1E1E, 16'h0E0E}; ch_q_data = {32'h0, 16'h1F1F, 16'h0F0F};
    ddc_flag = 4'b0011;
    tick();
    ddc_flag = 4'b0000;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    word("rstq.pre", 16'h0F0F, 1'b0, 2'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstq.valid", 32'(out_valid), 32'd0);
    chk("rstq.busy", 32'(busy), 32'd0);
    chk("rstq.data", 32'(out_data), 32'd0);
    ch_i_data = {32'h0, 16'h1A1A, 16'h0A0A}; ch_q_data = {32'h0, 16'h1B1B, 16'h0B0B};
    ddc_flag = 4'b0011;
    tick();
    ddc_flag = 4'b0000;
    tick();
    word("rstq.first", 16'h0A0A, 1'b1, 2'd0);

    // Global enable dropped during SEND_I
    do_reset();
    ch_i_data = {32'h0, 16'h1B1B, 16'h0A0A}; ch_q_data = {32'h0, 16'h1C1C, 16'h0B0B};
    ddc_flag = 4'b0011;
    tick();
    ddc_flag = 4'b0000;
    tick();
    enable = 1'b0;
    word("en.i0", 16'h0A0A, 1'b1, 2'd0);
    out_ready = 1'b1;
    tick();
    word("en.q0", 16'h0B0B, 1'b0, 2'd0);
    tick();
    chk("en.stop", 32'(out_valid), 32'd0);
    tick();
    tick();
    chk("en.still_stopped", 32'(out_valid), 32'd0);
    chk("en.retained", 32'(busy), 32'd1);
    enable = 1'b1;
    tick();
    word("en.i1", 16'h1B1B, 1'b1, 2'd1);
    tick();
    word("en.q1", 16'h1C1C, 1'b0, 2'd1);
    tick();
    chk("en.done_valid", 32'(out_valid), 32'd0);
    chk("en.done_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
